// File: rtl/uart_fifo_periph.sv
// Memory-mapped UART with TX/RX byte FIFOs, sticky overflow flags and an RX-level interrupt.
// Bus response one cycle after req_i; full FIFOs drop new bytes (unless popped that cycle) and flag overflow.

module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [WIDTH-1:0]             wdata_i,
  output logic [WIDTH-1:0]             rdata_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   level_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             push_ok, pop_ok;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A push into a full FIFO is only accepted when the head leaves in the same cycle.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end
endmodule

module uart_tx #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid_i,
  input  logic [7:0] data_i,
  output logic       ready_o,
  output logic       tx_o
);
  localparam int CPB = CLK_FREQ / BAUD_RATE;
  localparam int CW  = $clog2(CPB + 1);

  logic          busy_q, busy_d;
  logic [9:0]    shreg_q, shreg_d;
  logic [3:0]    bit_q, bit_d;
  logic [CW-1:0] cnt_q, cnt_d;

  assign ready_o = !busy_q;
  assign tx_o    = shreg_q[0];

  always_comb begin
    busy_d  = busy_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    if (!busy_q) begin
      if (valid_i) begin
        busy_d  = 1'b1;
        shreg_d = {1'b1, data_i, 1'b0};
        bit_d   = '0;
        cnt_d   = '0;
      end
    end else if (cnt_q == CW'(CPB - 1)) begin
      cnt_d   = '0;
      shreg_d = {1'b1, shreg_q[9:1]};
      if (bit_q == 4'd9) busy_d = 1'b0;
      else               bit_d  = bit_q + 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      shreg_q <= '1;
      bit_q   <= '0;
      cnt_q   <= '0;
    end else begin
      busy_q  <= busy_d;
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

module uart_rx #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_i,
  input  logic       ready_i,
  output logic       valid_o,
  output logic [7:0] data_o
);
  localparam int CPB = CLK_FREQ / BAUD_RATE;
  localparam int CW  = $clog2(CPB + 1);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          valid_q, valid_d;

  assign valid_o = valid_q;
  assign data_o  = shreg_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    valid_d = valid_q && !ready_i;
    case (state_q)
      S_IDLE: begin
        if (!rx_i) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      // Re-check the start bit at its centre so glitches do not start a frame.
      S_START: begin
        if (cnt_q == CW'(CPB / 2 - 1)) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_i ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == CW'(CPB - 1)) begin
          cnt_d   = '0;
          shreg_d = {rx_i, shreg_q[7:1]};
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == CW'(CPB - 1)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          if (rx_i) valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      valid_q <= valid_d;
    end
  end
endmodule

module uart_fifo_periph #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 115200,
  parameter int TX_DEPTH  = 16,
  parameter int RX_DEPTH  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [15:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        irq_o,
  input  logic        rx_i,
  output logic        tx_o
);
  localparam int TLW = $clog2(TX_DEPTH + 1);
  localparam int RLW = $clog2(RX_DEPTH + 1);

  logic [1:0]     rx_sync_q;
  logic [13:0]    word;
  logic           sel_data, sel_stat, sel_thr;
  logic           tx_push, tx_pop, tx_full, tx_empty, utx_rdy, tx_idle;
  logic           rx_pop, rx_full, rx_empty, rx_byte_vld;
  logic [7:0]     tx_head, rx_head, rx_byte;
  logic [TLW-1:0] tx_level;
  logic [RLW-1:0] rx_level;
  logic [31:0]    status, rdata_d, rdata_q;
  logic           rvalid_q, irq_q, irq_d, stat_wr;
  logic [7:0]     thresh_q, thresh_d;
  logic           rx_ovf_q, rx_ovf_d, tx_ovf_q, tx_ovf_d;
  logic           unused_bits;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_sync_q <= 2'b11;
    else        rx_sync_q <= {rx_sync_q[0], rx_i};
  end

  assign word     = addr_i[15:2];
  assign sel_data = (word == 14'd0);
  assign sel_stat = (word == 14'd1);
  assign sel_thr  = (word == 14'd2);
  assign unused_bits = ^{addr_i[1:0], wdata_i[31:8]};

  assign tx_push = req_i && we_i && sel_data;
  assign tx_pop  = !tx_empty && utx_rdy;
  assign tx_idle = tx_empty && utx_rdy;
  assign rx_pop  = req_i && !we_i && sel_data && !rx_empty;
  assign stat_wr = req_i && we_i && sel_stat;

  sync_fifo #(.DEPTH(TX_DEPTH), .WIDTH(8)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n), .push_i(tx_push), .pop_i(tx_pop), .wdata_i(wdata_i[7:0]),
    .rdata_o(tx_head), .full_o(tx_full), .empty_o(tx_empty), .level_o(tx_level)
  );

  sync_fifo #(.DEPTH(RX_DEPTH), .WIDTH(8)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n), .push_i(rx_byte_vld), .pop_i(rx_pop), .wdata_i(rx_byte),
    .rdata_o(rx_head), .full_o(rx_full), .empty_o(rx_empty), .level_o(rx_level)
  );

  uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) u_tx (
    .clk(clk), .rst_n(rst_n), .valid_i(!tx_empty), .data_i(tx_head),
    .ready_o(utx_rdy), .tx_o(tx_o)
  );

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) u_rx (
    .clk(clk), .rst_n(rst_n), .rx_i(rx_sync_q[1]), .ready_i(1'b1),
    .valid_o(rx_byte_vld), .data_o(rx_byte)
  );

  assign status = {8'h00, 8'(tx_level), 8'(rx_level), 3'b000,
                   tx_ovf_q, rx_ovf_q, tx_idle, !rx_empty, tx_full};

  always_comb begin
    rdata_d = '0;
    if (req_i && !we_i) begin
      case (word)
        14'd0:   rdata_d = rx_empty ? 32'hFFFF_FFFF : {24'h0, rx_head};
        14'd1:   rdata_d = status;
        14'd2:   rdata_d = {24'h0, thresh_q};
        default: rdata_d = '0;
      endcase
    end
  end

  // A new overflow wins over a same-cycle W1C clear.
  assign tx_ovf_d = (tx_push && tx_full && !tx_pop) || (tx_ovf_q && !(stat_wr && wdata_i[4]));
  assign rx_ovf_d = (rx_byte_vld && rx_full && !rx_pop) || (rx_ovf_q && !(stat_wr && wdata_i[3]));
  assign thresh_d = (req_i && we_i && sel_thr) ? wdata_i[7:0] : thresh_q;
  assign irq_d    = (thresh_q != 8'h00) && (8'(rx_level) >= thresh_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      irq_q    <= 1'b0;
      thresh_q <= '0;
      rx_ovf_q <= 1'b0;
      tx_ovf_q <= 1'b0;
    end else begin
      rvalid_q <= req_i;
      rdata_q  <= rdata_d;
      irq_q    <= irq_d;
      thresh_q <= thresh_d;
      rx_ovf_q <= rx_ovf_d;
      tx_ovf_q <= tx_ovf_d;
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign irq_o    = irq_q;
endmodule
